// File: rtl/tomasula_types.sv
// Shared decode-to-issue types: the decoded control word and its opcode class.
package tomasula_types;

    localparam int unsigned IQ_DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OpAlu,
        OpMul,
        OpLoad,
        OpStore,
        OpBranch
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ctl_word;

endpackage

// File: rtl/instr_queue.sv
// Instruction queue between decode and dispatch: flop-based circular FIFO of ctl_word.
// Define IQ_BYPASS_EN to let an empty queue hand the offered word straight to dispatch.
module instr_queue
    import tomasula_types::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_iq,
    input  ctl_word                  control_word,
    output logic                     ack_o,
    input  logic                     flush,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output ctl_word                  deq_word,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    ctl_word         r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;

    logic            w_bypass;
    logic            w_push;
    logic            w_pop;

    assign count = r_count;
    assign full  = (r_count == (PW+1)'(DEPTH));
    assign empty = (r_count == '0);

    // ack_o never looks at deq_ready, so decode and dispatch cannot form a loop.
    assign ack_o = ld_iq & ~full & ~flush;

`ifdef IQ_BYPASS_EN
    assign w_bypass  = empty & ld_iq & ~flush;
    assign deq_valid = ~empty | w_bypass;
    assign deq_word  = w_bypass ? control_word : r_mem[r_head];
`else
    assign w_bypass  = 1'b0;
    assign deq_valid = ~empty;
    assign deq_word  = r_mem[r_head];
`endif

    // A bypassed word taken by dispatch never touches storage.
    assign w_push = ack_o & ~(w_bypass & deq_ready);
    assign w_pop  = ~empty & deq_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_tail] <= control_word;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed scenarios then randomized traffic against a queue model.
module tb_instr_queue;
    import tomasula_types::*;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_iq = 1'b0;
    ctl_word    control_word = '0;
    logic       ack_o;
    logic       flush = 1'b0;
    logic       deq_ready = 1'b0;
    logic       deq_valid;
    ctl_word    deq_word;
    logic       full;
    logic       empty;
    logic [3:0] count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    ctl_word     exp_q[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_iq        (ld_iq),
        .control_word (control_word),
        .ack_o        (ack_o),
        .flush        (flush),
        .deq_ready    (deq_ready),
        .deq_valid    (deq_valid),
        .deq_word     (deq_word),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_word mk(input logic [31:0] pc);
        ctl_word w;
        w.op  = op_e'($urandom_range(0, 4));
        w.pc  = pc;
        w.rd  = 5'($urandom);
        w.rs1 = 5'($urandom);
        w.rs2 = 5'($urandom);
        w.imm = $urandom;
        return w;
    endfunction

    // Monitor: every word dispatch actually takes must be the oldest accepted one.
    always @(negedge clk) begin
        if (!rst && !flush && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deq_unexpected: got pc %0h expected no entry at %0t",
                         deq_word.pc, $time);
            end else begin
                chk("deq_word", deq_word, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic ld, input ctl_word w, input logic rdy, input logic fl,
                         input logic rs, output logic acked);
        int unsigned n;
        logic        exp_ack;
        logic        exp_dv;
        ld_iq        = ld;
        control_word = w;
        deq_ready    = rdy;
        flush        = fl;
        rst          = rs;
        #1;
        n       = exp_q.size();
        exp_ack = ld && !fl && (n != DEPTH);
        exp_dv  = (n != 0);
`ifdef IQ_BYPASS_EN
        if (n == 0 && ld && !fl) exp_dv = 1'b1;
`endif
        chk("count", count, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("ack_o", ack_o, exp_ack);
        chk("deq_valid", deq_valid, exp_dv);
        if (exp_ack && !rs) exp_q.push_back(w);
        acked = exp_ack;
        @(posedge clk);
        #1;
        if (fl || rs) exp_q.delete();
    endtask

    initial begin
        logic    a;
        logic    pend;
        ctl_word pw;
        logic [31:0] pc_next;

        @(posedge clk);
        #1;
        // Post-reset idle.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        // Fill 0x60..0x7C, then hold a ninth offer against a full queue.
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(32'h60 + 4 * i), 1'b0, 1'b0, 1'b0, a);
        pw = mk(32'h80);
        for (int i = 0; i < 2; i++) cycle(1'b1, pw, 1'b0, 1'b0, 1'b0, a);

        // Drain in order, then observe empty.
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        // Move head to 6, leave 3 entries, then push+pop for 10 cycles across the wrap.
        for (int i = 0; i < 6; i++) cycle(1'b1, mk(32'h100 + 4 * i), 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h200 + 4 * i), 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(32'h300 + 4 * i), 1'b1, 1'b0, 1'b0, a);

        // Grow to 5, then flush colliding with a push and a pop.
        for (int i = 0; i < 2; i++) cycle(1'b1, mk(32'h400 + 4 * i), 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, mk(32'h500), 1'b1, 1'b1, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        // Offer into an empty queue with dispatch ready.
        cycle(1'b1, mk(32'h40), 1'b1, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        // Reset mid-stream with traffic on every input.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(32'h600 + 4 * i), 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, mk(32'h700), 1'b1, 1'b1, 1'b1, a);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        // Random traffic; an unacknowledged offer is held unchanged until accepted.
        pend    = 1'b0;
        pw      = '0;
        pc_next = 32'h1000;
        for (int i = 0; i < 2000; i++) begin
            logic ld;
            logic rdy;
            logic fl;
            logic rs;
            if (!pend && $urandom_range(0, 99) < 60) begin
                pw      = mk(pc_next);
                pc_next = pc_next + 4;
                pend    = 1'b1;
            end
            ld  = pend;
            rdy = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 3);
            rs  = ($urandom_range(0, 199) < 1);
            cycle(ld, pw, rdy, fl, rs, a);
            if (a) pend = 1'b0;
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter: DEPTH, default 8, entry count; power of two, minimum 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ld_iq  in  1  decode stage requests enqueue; held high until ack_o is seen.
REQ-005 control_word  in  tomasula_types::ctl_word  decoded instruction offered with ld_iq.
REQ-006 ack_o  out  1  enqueue accepted this cycle; combinational.
REQ-007 flush  in  1  discard all entries (branch mispredict/recovery).
REQ-008 deq_ready  in  1  dispatch/reservation-station side can take an entry this cycle.
REQ-009 deq_valid  out  1  deq_word holds a valid entry.
REQ-010 deq_word  out  tomasula_types::ctl_word  head entry.
REQ-011 full  out  1  count == DEPTH.
REQ-012 empty  out  1  count == 0.
REQ-013 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-014 Storage: circular buffer, DEPTH entries, head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus count register.
REQ-015 ack_o = ld_iq & ~full & ~flush; depends on no other input, so no loop with deq_ready.
REQ-016 Push: ack_o high -> control_word written at tail on the clock edge, tail+1, count+1.
REQ-017 Each ack_o cycle accepts exactly one entry; ld_iq held across cycles with ack_o low writes nothing.
REQ-018 Pop: deq_valid & deq_ready -> head+1, count-1 on the clock edge.
REQ-019 deq_valid = ~empty (bypass case: REQ-027); deq_word = entry at head.
REQ-020 Push and pop in the same cycle: count unchanged; both pointers advance.
REQ-021 Full: ack_o low even if a pop occurs that cycle; the push is taken on a later cycle.
REQ-022 Empty: no pop; deq_word value is don't-care.
REQ-023 Flush: head, tail and count cleared on the edge; flush overrides push and pop that cycle; deq_valid still follows REQ-019 during the flush cycle.
REQ-024 Latency without bypass: entry pushed at edge N is visible on deq_valid/deq_word after edge N.
REQ-025 Order: strict FIFO; no reordering, no entry dropped except by flush or rst.

Reset
REQ-026 rst high: head=0, tail=0, count=0 on the edge; afterwards empty=1, full=0, deq_valid=0, ack_o=0 when ld_iq=0. rst overrides flush, push and pop, including mid-stream with any occupancy; stored data is not cleared.

Configuration
REQ-027 IQ_BYPASS_EN defined: when empty & ld_iq & ~flush, deq_valid=1 and deq_word=control_word combinationally. If deq_ready is also high, the entry is consumed directly; it is not written, and pointers and count are unchanged. If deq_ready is low, the normal push occurs.
REQ-028 IQ_BYPASS_EN undefined: no combinational path from ld_iq/control_word to deq_*; minimum latency is one cycle (REQ-024).

Structure
REQ-029 ctl_word and its op enum stay in tomasula_types; IQ_DEPTH_DEFAULT constant lives in that package; no new typedefs local to the module.
REQ-030 Single module; no sub-modules; storage is an unpacked array of ctl_word (flop-based, no RAM macro).

Verification
REQ-031 Bench covers these directed scenarios:
- Post-reset: rst 1 cycle, ld_iq=0 -> count=0, empty=1, full=0, deq_valid=0.
- Fill: DEPTH=8, ld_iq held, deq_ready=0, pc 0x60..0x7C -> ack_o high for 8 cycles, then full=1, ack_o=0 while ld_iq=1.
- Drain order: after fill, deq_ready=1 -> deq_word.pc = 0x60, 0x64, ... 0x7C over 8 cycles; then empty=1.
- Wrap and simultaneous events: count=3, head=6; push and pop every cycle for 10 cycles -> count stays 3, pointers wrap 7->0, order preserved.
- Flush collision: count=5, flush=1 with ld_iq=1 and deq_ready=1 -> ack_o=0; next cycle count=0, empty=1.
- Bypass: IQ_BYPASS_EN, empty, ld_iq=1, deq_ready=1, pc=0x40 -> same cycle deq_valid=1, deq_word.pc=0x40, ack_o=1; next cycle count=0. Without the macro: deq_valid=0 that cycle, 1 the next.
